// File: rtl/sram_to_fifo_pkg.sv
// Shared definitions for the SRAM-to-FIFO read mover: default widths and
// the 3-bit FSM state encoding.
package sram_to_fifo_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 10;
    localparam int DEF_LW = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PUSH = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sram_to_fifo_ctr.sv
// Address and remaining-word counter for the read mover. Loads base/length
// when a transfer is accepted and steps once per word handed to the FIFO.
// The address wraps naturally modulo 2^aw.
module sram_to_fifo_ctr
    import sram_to_fifo_pkg::*;
#(
    parameter int aw = DEF_AW,
    parameter int lw = DEF_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [aw-1:0] base,
    input  logic [lw-1:0] len,
    output logic [aw-1:0] addr,
    output logic [lw-1:0] rem,
    output logic          last
);

    // Load on accept, otherwise advance one word per completed push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            rem  <= '0;
        end else if (load) begin
            addr <= base;
            rem  <= len;
        end else if (step) begin
            addr <= addr + aw'(1);
            rem  <= rem - lw'(1);
        end
    end

    // The word currently in flight is the final one of the block.
    assign last = (rem == lw'(1));

endmodule

// File: rtl/sram_to_fifo.sv
// Read-side DMA mover: reads a block of words from SRAM, one read at a time,
// and pushes each word into a FIFO, stalling while the FIFO is full.
//
// Handshakes: sram_read_start is a one-cycle strobe; sram_address holds from
// the strobe until sram_read_valid, which may arrive in the strobe cycle or
// any later cycle and is honoured only while waiting for data. push is a
// one-cycle strobe issued only when full was low at the deciding edge, with
// fifo_data_out valid in that same cycle. abort drops the transfer at the
// next edge; a late sram_read_valid is then ignored.
//
// The FSM state is the named register `state` for observation by checkers.
module sram_to_fifo
    import sram_to_fifo_pkg::*;
#(
    parameter int dw = DEF_DW,
    parameter int aw = DEF_AW,
    parameter int lw = DEF_LW
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          start,
    input  logic          abort,
    input  logic [aw-1:0] base_address,
    input  logic [lw-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          sram_read_start,
    output logic [aw-1:0] sram_address,
    input  logic [dw-1:0] sram_data_in,
    input  logic          sram_read_valid,
    input  logic          full,
    output logic          push,
    output logic [dw-1:0] fifo_data_out
);

    state_t        state;
    logic [dw-1:0] data_q;
    logic [aw-1:0] addr;
    logic [lw-1:0] rem;
    logic          last;
    logic          ctr_load;
    logic          ctr_step;

    // Counter control follows the same decisions the FSM takes this edge.
    always_comb begin
        ctr_load = (state == ST_IDLE) && start && !abort && (length != '0);
        ctr_step = (state == ST_PUSH) && !full && !abort;
    end

    sram_to_fifo_ctr #(
        .aw(aw),
        .lw(lw)
    ) u_ctr (
        .clk (wb_clk),
        .rst (wb_rst),
        .load(ctr_load),
        .step(ctr_step),
        .base(base_address),
        .len (length),
        .addr(addr),
        .rem (rem),
        .last(last)
    );

    // Transfer sequencing with registered outputs; strobes default low.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            sram_read_start <= 1'b0;
            sram_address    <= '0;
            push            <= 1'b0;
            fifo_data_out   <= '0;
            data_q          <= '0;
        end else begin
            sram_read_start <= 1'b0;
            push            <= 1'b0;
            done            <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // abort alongside start means the request is refused
                        if (start && !abort) begin
                            busy <= 1'b1;
                            if (length != '0) begin
                                state <= ST_REQ;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (!full) begin
                            sram_read_start <= 1'b1;
                            sram_address    <= addr;
                            state           <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (sram_read_valid) begin
                            data_q <= sram_data_in;
                            state  <= ST_PUSH;
                        end
                    end
                    ST_PUSH: begin
                        if (!full) begin
                            push          <= 1'b1;
                            fifo_data_out <= data_q;
                            if (last) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_REQ;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
